dbg_sb_access_ctrl: RTL and testbench

//  System-bus access (SBA) sequencer of the debug module. Turns SBCS/SBAddress/SBData

---
 rtl/dbg_sb_access_ctrl_pkg.sv | 22 ++
 rtl/dbg_sb_access_ctrl_lane.sv | 45 ++++
 rtl/dbg_sb_access_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dbg_sb_access_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_sb_access_ctrl_pkg.sv
// Shared types and constants for the system-bus access sequencer.
// Contents:
//   sba_state_e  - sequencer states
//   SbErr*       - SBCS.sberror codes reported by the sequencer
package dbg_sb_access_ctrl_pkg;

  typedef enum logic [2:0] {
    Idle,
    Read,
    Write,
    WaitRead,
    WaitWrite
  } sba_state_e;

  localparam logic [2:0] SbErrNone    = 3'd0;
  localparam logic [2:0] SbErrTimeout = 3'd1;
  localparam logic [2:0] SbErrBadAddr = 3'd2;
  localparam logic [2:0] SbErrAlign   = 3'd3;
  localparam logic [2:0] SbErrSize    = 3'd4;
  localparam logic [2:0] SbErrOther   = 3'd7;

endpackage

// File: rtl/dbg_sb_access_ctrl_lane.sv
// Byte-lane steering for system-bus accesses (purely combinational).
// Ports:
//   offset_i  - byte offset of the access inside a bus word (address lsbs)
//   access_i  - access size as log2(bytes)
//   wdata_i   - right-aligned write data
//   rdata_i   - raw bus read data
//   be_o      - byte enables for the access
//   wdata_o   - write data masked to size and moved to its lanes
//   rdata_o   - read data moved down to bit 0 and masked to size
module dbg_sb_lane #(
  parameter int BusWidth = 32
) (
  input  logic [$clog2(BusWidth/8)-1:0] offset_i,
  input  logic [2:0]                    access_i,
  input  logic [BusWidth-1:0]           wdata_i,
  input  logic [BusWidth-1:0]           rdata_i,
  output logic [BusWidth/8-1:0]         be_o,
  output logic [BusWidth-1:0]           wdata_o,
  output logic [BusWidth-1:0]           rdata_o
);

  localparam int BeW = BusWidth / 8;

  int                  size_bytes;
  logic [BeW-1:0]      byte_mask;
  logic [BusWidth-1:0] bit_mask;

  // Build size masks with loops so an access as wide as the bus never needs
  // a shift by the full word width.
  always_comb begin
    size_bytes = 1 << access_i;
    byte_mask  = '0;
    bit_mask   = '0;
    for (int i = 0; i < BeW; i++) begin
      byte_mask[i] = (i < size_bytes);
    end
    for (int i = 0; i < BusWidth; i++) begin
      bit_mask[i] = (i < size_bytes * 8);
    end
    be_o    = byte_mask << offset_i;
    wdata_o = (wdata_i & bit_mask) << {offset_i, 3'b000};
    rdata_o = (rdata_i >> {offset_i, 3'b000}) & bit_mask;
  end

endmodule

// File: rtl/dbg_sb_access_ctrl.sv
// System-bus access sequencer of the debug module. Converts SBAddress/SBData
// register events into single req/gnt/r_valid bus transactions, checks size
// and alignment, steers byte lanes, auto-increments and reports sberror codes.
// Ports:
//   clk_i, rst_ni              - clock, async active-low reset
//   dmactive_i                 - low aborts/quiesces the sequencer
//   sbaddress_*, sbdata_*,
//   sbreadon*, sbautoincrement_i, sbaccess_i - CSR events and SBCS fields
//   sbaddress_o, sbdata_o, sbdata_valid_o     - address/read-data registers
//   sbbusy_o, sberror_valid_o, sberror_o      - status towards SBCS
//   master_*                   - bus master port
module dbg_sb_access_ctrl
  import dbg_sb_access_ctrl_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [BusWidth-1:0]   sbaddress_i,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o,
  output logic                  master_req_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic                  master_r_err_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i
);

  localparam int         BeW       = BusWidth / 8;
  localparam int         OffW      = $clog2(BeW);
  localparam logic [2:0] MaxAccess = 3'(OffW);

  sba_state_e          state_q, state_d;
  logic [BusWidth-1:0] sbaddress_q, sbdata_q, add_q, wdata_q;
  logic [BeW-1:0]      be_q;
  logic                we_q, abort_q;
  logic [2:0]          access_q;
  logic                sbdata_valid_q, sberror_valid_q;
  logic [2:0]          sberror_q;

  logic                trig_write, trig_read;
  logic [BusWidth-1:0] eff_addr, inc;
  logic [OffW-1:0]     align_mask, lane_off;
  logic [2:0]          lane_access;
  logic                size_err, align_err;
  logic                issue, err_set, done_ok, rd_done;
  logic [2:0]          err_code;
  logic [BeW-1:0]      lane_be;
  logic [BusWidth-1:0] lane_wdata, lane_rdata;

  assign trig_write = dmactive_i & sbdata_write_valid_i;
  assign trig_read  = dmactive_i & ((sbaddress_write_valid_i & sbreadonaddr_i) |
                                    (sbdata_read_valid_i & sbreadondata_i));

  // A read-on-address uses the value being written this cycle.
  assign eff_addr = sbaddress_write_valid_i ? sbaddress_i : sbaddress_q;
  assign size_err = (sbaccess_i > MaxAccess);

  // Low address bits that must be zero for the requested access size.
  always_comb begin
    align_mask = '0;
    for (int i = 0; i < OffW; i++) begin
      align_mask[i] = (i < int'(sbaccess_i));
    end
  end
  assign align_err = |(eff_addr[OffW-1:0] & align_mask);

  // The lane unit serves the trigger while idle and the latched access
  // afterwards, when only read-data alignment is needed.
  assign lane_off    = (state_q == Idle) ? eff_addr[OffW-1:0] : add_q[OffW-1:0];
  assign lane_access = (state_q == Idle) ? sbaccess_i : access_q;

  dbg_sb_lane #(.BusWidth(BusWidth)) u_lane (
    .offset_i (lane_off),
    .access_i (lane_access),
    .wdata_i  (sbdata_i),
    .rdata_i  (master_r_rdata_i),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  // Next state plus one-cycle control strobes. A response that arrives after
  // an abort only returns the sequencer to Idle; it reports nothing.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    err_set  = 1'b0;
    err_code = SbErrNone;
    done_ok  = 1'b0;
    unique case (state_q)
      Idle: begin
        if (trig_write || trig_read) begin
          if (size_err) begin
            err_set  = 1'b1;
            err_code = SbErrSize;
          end else if (align_err) begin
            err_set  = 1'b1;
            err_code = SbErrAlign;
          end else begin
            issue   = 1'b1;
            state_d = trig_write ? Write : Read;
          end
        end
      end
      Read: begin
        if (master_gnt_i)     state_d = WaitRead;
        else if (!dmactive_i) state_d = Idle;
      end
      Write: begin
        if (master_gnt_i)     state_d = WaitWrite;
        else if (!dmactive_i) state_d = Idle;
      end
      WaitRead, WaitWrite: begin
        if (master_r_valid_i) begin
          state_d = Idle;
          if (!abort_q && dmactive_i) begin
            if (master_r_err_i) begin
              err_set  = 1'b1;
              err_code = SbErrBadAddr;
            end else begin
              done_ok = 1'b1;
            end
          end
        end
      end
      default: state_d = Idle;
    endcase
  end

  // State register and the sticky abort flag for the transfer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        abort_q <= 1'b0;
      end else if (!dmactive_i && (state_q != Idle)) begin
        abort_q <= 1'b1;
      end
    end
  end

  assign rd_done = done_ok && (state_q == WaitRead);
  assign inc     = {{(BusWidth-1){1'b0}}, 1'b1} << access_q;

  // Address, data, status and latched bus request registers. A DMI address
  // write always takes precedence over auto-increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbaddress_q     <= '0;
      sbdata_q        <= '0;
      sbdata_valid_q  <= 1'b0;
      sberror_valid_q <= 1'b0;
      sberror_q       <= SbErrNone;
      add_q           <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      we_q            <= 1'b0;
      access_q        <= '0;
    end else begin
      sbdata_valid_q  <= rd_done;
      sberror_valid_q <= err_set;
      if (err_set) sberror_q <= err_code;
      if (rd_done) sbdata_q <= lane_rdata;
      if (issue) begin
        add_q    <= eff_addr;
        we_q     <= trig_write;
        wdata_q  <= lane_wdata;
        be_q     <= lane_be;
        access_q <= sbaccess_i;
      end
      if (done_ok && sbautoincrement_i) sbaddress_q <= sbaddress_q + inc;
      if (sbaddress_write_valid_i) sbaddress_q <= sbaddress_i;
    end
  end

  assign sbaddress_o     = sbaddress_q;
  assign sbdata_o        = sbdata_q;
  assign sbdata_valid_o  = sbdata_valid_q;
  assign sbbusy_o        = (state_q != Idle);
  assign sberror_valid_o = sberror_valid_q;
  assign sberror_o       = sberror_q;
  assign master_req_o    = (state_q == Read) || (state_q == Write);
  assign master_add_o    = add_q;
  assign master_we_o     = we_q;
  assign master_wdata_o  = wdata_q;
  assign master_be_o     = be_q;

endmodule

// File: tb/tb_dbg_sb_access_ctrl.sv
// Self-checking bench for dbg_sb_access_ctrl (BusWidth = 32): a table of
// directed accesses, randomized accesses checked against an arithmetic model,
// and hand-written dmactive abort sequences.
module tb_dbg_sb_access_ctrl;
  import dbg_sb_access_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmactive_i;
  logic [31:0] sbaddress_i;
  logic        sbaddress_write_valid_i;
  logic        sbreadonaddr_i;
  logic        sbautoincrement_i;
  logic [2:0]  sbaccess_i;
  logic        sbreadondata_i;
  logic [31:0] sbdata_i;
  logic        sbdata_read_valid_i;
  logic        sbdata_write_valid_i;
  logic [31:0] sbaddress_o;
  logic [31:0] sbdata_o;
  logic        sbdata_valid_o;
  logic        sbbusy_o;
  logic        sberror_valid_o;
  logic [2:0]  sberror_o;
  logic        master_req_o;
  logic [31:0] master_add_o;
  logic        master_we_o;
  logic [31:0] master_wdata_o;
  logic [3:0]  master_be_o;
  logic        master_gnt_i;
  logic        master_r_valid_i;
  logic        master_r_err_i;
  logic [31:0] master_r_rdata_i;

  dbg_sb_access_ctrl #(.BusWidth(32)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .dmactive_i              (dmactive_i),
    .sbaddress_i             (sbaddress_i),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbaccess_i              (sbaccess_i),
    .sbreadondata_i          (sbreadondata_i),
    .sbdata_i                (sbdata_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbaddress_o             (sbaddress_o),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbbusy_o                (sbbusy_o),
    .sberror_valid_o         (sberror_valid_o),
    .sberror_o               (sberror_o),
    .master_req_o            (master_req_o),
    .master_add_o            (master_add_o),
    .master_we_o             (master_we_o),
    .master_wdata_o          (master_wdata_o),
    .master_be_o             (master_be_o),
    .master_gnt_i            (master_gnt_i),
    .master_r_valid_i        (master_r_valid_i),
    .master_r_err_i          (master_r_err_i),
    .master_r_rdata_i        (master_r_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_write;
    logic        addr_write;
    logic        also_read;
    logic        autoinc;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        rerr;
    int          gnt_wait;
    int          rsp_wait;
    logic [2:0]  exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [31:0] exp_next;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_addr = 32'h0;
  logic [31:0] exp_sbdata = 32'h0;
  vec_t        tbl[11];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected results from the access rules: size check, then alignment,
  // then lane placement and auto-increment by the access size.
  function automatic vec_t modelExpect(input vec_t v);
    vec_t        r = v;
    int unsigned bytes, off;
    logic [63:0] m;
    logic [31:0] mask;
    bytes = 1 << v.size;
    off   = v.addr % 4;
    m     = (64'd1 << (8 * bytes)) - 64'd1;
    mask  = m[31:0];
    r.exp_be    = 4'(((1 << bytes) - 1) << off);
    r.exp_wdata = (v.data & mask) << (8 * off);
    r.exp_rdata = (v.rdata >> (8 * off)) & mask;
    if (v.size > 3'd2)            r.exp_err = SbErrSize;
    else if (v.addr % bytes != 0) r.exp_err = SbErrAlign;
    else if (v.rerr)              r.exp_err = SbErrBadAddr;
    else                          r.exp_err = SbErrNone;
    r.exp_next = (r.exp_err == SbErrNone && v.autoinc) ? v.addr + bytes : v.addr;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    if (v.addr_write && v.is_write) begin
      sbaddress_i = v.addr;
      sbaddress_write_valid_i = 1'b1;
      @(negedge clk_i);
      sbaddress_write_valid_i = 1'b0;
    end
    sbaccess_i = v.size;
    sbautoincrement_i = v.autoinc;
    if (v.is_write) begin
      sbdata_i = v.data;
      sbdata_write_valid_i = 1'b1;
      if (v.also_read) begin
        sbreadondata_i = 1'b1;
        sbdata_read_valid_i = 1'b1;
      end
    end else if (v.addr_write) begin
      sbaddress_i = v.addr;
      sbreadonaddr_i = 1'b1;
      sbaddress_write_valid_i = 1'b1;
    end else begin
      sbreadondata_i = 1'b1;
      sbdata_read_valid_i = 1'b1;
    end
    @(negedge clk_i);
    sbdata_write_valid_i = 1'b0;
    sbdata_read_valid_i = 1'b0;
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i = 1'b0;
    sbreadondata_i = 1'b0;

    if (v.exp_err == SbErrSize || v.exp_err == SbErrAlign) begin
      checkOutput("precheck_err_valid", 32'(sberror_valid_o), 32'd1);
      checkOutput("precheck_err_code", 32'(sberror_o), 32'(v.exp_err));
      checkOutput("precheck_no_req", 32'(master_req_o), 32'd0);
      checkOutput("precheck_busy", 32'(sbbusy_o), 32'd0);
      @(negedge clk_i);
      checkOutput("precheck_err_pulse_end", 32'(sberror_valid_o), 32'd0);
      checkOutput("precheck_no_req_later", 32'(master_req_o), 32'd0);
      checkOutput("precheck_addr", sbaddress_o, v.exp_next);
      model_addr = v.exp_next;
      return;
    end

    checkOutput("req", 32'(master_req_o), 32'd1);
    checkOutput("busy", 32'(sbbusy_o), 32'd1);
    checkOutput("add", master_add_o, v.addr);
    checkOutput("we", 32'(master_we_o), 32'(v.is_write));
    checkOutput("be", 32'(master_be_o), 32'(v.exp_be));
    if (v.is_write) checkOutput("wdata", master_wdata_o, v.exp_wdata);

    // Grant stall; a write trigger injected while busy must be ignored.
    for (int k = 0; k < v.gnt_wait; k++) begin
      if (k == 1) begin
        sbdata_i = ~v.data;
        sbdata_write_valid_i = 1'b1;
      end
      @(negedge clk_i);
      sbdata_write_valid_i = 1'b0;
      checkOutput("stall_req", 32'(master_req_o), 32'd1);
      checkOutput("stall_add", master_add_o, v.addr);
      checkOutput("stall_we", 32'(master_we_o), 32'(v.is_write));
      checkOutput("stall_be", 32'(master_be_o), 32'(v.exp_be));
      if (v.is_write) checkOutput("stall_wdata", master_wdata_o, v.exp_wdata);
    end
    master_gnt_i = 1'b1;
    @(negedge clk_i);
    master_gnt_i = 1'b0;
    checkOutput("req_after_gnt", 32'(master_req_o), 32'd0);
    checkOutput("busy_wait", 32'(sbbusy_o), 32'd1);

    for (int k = 0; k < v.rsp_wait; k++) @(negedge clk_i);
    master_r_valid_i = 1'b1;
    master_r_err_i = v.rerr;
    master_r_rdata_i = v.rdata;
    @(negedge clk_i);
    master_r_valid_i = 1'b0;
    master_r_err_i = 1'b0;

    checkOutput("busy_done", 32'(sbbusy_o), 32'd0);
    checkOutput("no_req_done", 32'(master_req_o), 32'd0);
    if (v.rerr) begin
      checkOutput("bus_err_valid", 32'(sberror_valid_o), 32'd1);
      checkOutput("bus_err_code", 32'(sberror_o), 32'(v.exp_err));
      checkOutput("bus_err_no_data", 32'(sbdata_valid_o), 32'd0);
      checkOutput("bus_err_sbdata", sbdata_o, exp_sbdata);
    end else if (!v.is_write) begin
      checkOutput("rd_valid", 32'(sbdata_valid_o), 32'd1);
      checkOutput("rd_data", sbdata_o, v.exp_rdata);
      exp_sbdata = v.exp_rdata;
    end else begin
      checkOutput("wr_no_valid", 32'(sbdata_valid_o), 32'd0);
      checkOutput("wr_no_err", 32'(sberror_valid_o), 32'd0);
    end
    checkOutput("next_addr", sbaddress_o, v.exp_next);
    model_addr = v.exp_next;
    @(negedge clk_i);
    checkOutput("valid_pulse_end", 32'(sbdata_valid_o), 32'd0);
    checkOutput("idle_no_req", 32'(master_req_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst_ni = 1'b0;
    dmactive_i = 1'b1;
    sbaddress_i = '0;
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i = 1'b0;
    sbautoincrement_i = 1'b0;
    sbaccess_i = 3'd2;
    sbreadondata_i = 1'b0;
    sbdata_i = '0;
    sbdata_read_valid_i = 1'b0;
    sbdata_write_valid_i = 1'b0;
    master_gnt_i = 1'b0;
    master_r_valid_i = 1'b0;
    master_r_err_i = 1'b0;
    master_r_rdata_i = '0;
    repeat (2) @(negedge clk_i);

    checkOutput("rst_sbaddress", sbaddress_o, 32'h0);
    checkOutput("rst_sbdata", sbdata_o, 32'h0);
    checkOutput("rst_data_valid", 32'(sbdata_valid_o), 32'd0);
    checkOutput("rst_busy", 32'(sbbusy_o), 32'd0);
    checkOutput("rst_err_valid", 32'(sberror_valid_o), 32'd0);
    checkOutput("rst_err", 32'(sberror_o), 32'd0);
    checkOutput("rst_req", 32'(master_req_o), 32'd0);
    checkOutput("rst_add", master_add_o, 32'h0);
    checkOutput("rst_be", 32'(master_be_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // is_write addr_write also_read autoinc addr size data rdata rerr gnt rsp
    // exp_err exp_be exp_wdata exp_rdata exp_next
    tbl[0]  = '{0,1,0,0, 32'h1000, 3'd2, 32'h0, 32'hDEADBEEF, 0, 0, 1,
                3'd0, 4'hF, 32'h0, 32'hDEADBEEF, 32'h1000};
    tbl[1]  = '{1,1,0,1, 32'h2003, 3'd0, 32'hA5, 32'h0, 0, 0, 0,
                3'd0, 4'h8, 32'hA500_0000, 32'h0, 32'h2004};
    tbl[2]  = '{0,1,0,0, 32'h3000, 3'd3, 32'h0, 32'h0, 0, 0, 0,
                3'd4, 4'h0, 32'h0, 32'h0, 32'h3000};
    tbl[3]  = '{0,1,0,0, 32'h2001, 3'd1, 32'h0, 32'h0, 0, 0, 0,
                3'd3, 4'h0, 32'h0, 32'h0, 32'h2001};
    tbl[4]  = '{0,1,0,1, 32'h1004, 3'd2, 32'h0, 32'hCAFEF00D, 1, 1, 2,
                3'd2, 4'hF, 32'h0, 32'h0, 32'h1004};
    tbl[5]  = '{1,1,0,1, 32'hFFFF_FFFC, 3'd2, 32'h1357_2468, 32'h0, 0, 5, 1,
                3'd0, 4'hF, 32'h1357_2468, 32'h0, 32'h0};
    tbl[6]  = '{0,0,0,1, 32'h0, 3'd1, 32'h0, 32'h1234_5678, 0, 0, 0,
                3'd0, 4'h3, 32'h0, 32'h5678, 32'h2};
    tbl[7]  = '{0,0,0,1, 32'h2, 3'd0, 32'h0, 32'hAABB_CCDD, 0, 2, 1,
                3'd0, 4'h4, 32'h0, 32'hBB, 32'h3};
    tbl[8]  = '{1,1,1,0, 32'h1006, 3'd1, 32'hFFFF_BEEF, 32'h0, 0, 0, 0,
                3'd0, 4'hC, 32'hBEEF_0000, 32'h0, 32'h1006};
    tbl[9]  = '{1,0,0,1, 32'h1006, 3'd0, 32'h5A, 32'h0, 0, 1, 0,
                3'd0, 4'h4, 32'h005A_0000, 32'h0, 32'h1007};
    tbl[10] = '{1,0,0,0, 32'h1007, 3'd2, 32'h0, 32'h0, 0, 0, 0,
                3'd3, 4'h0, 32'h0, 32'h0, 32'h1007};
    for (int i = 0; i < 11; i++) applyStimulus(tbl[i]);

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.is_write   = 1'($urandom_range(0, 1));
      v.addr_write = ($urandom_range(0, 2) != 0);
      v.also_read  = 1'b0;
      v.autoinc    = 1'($urandom_range(0, 1));
      v.size       = 3'($urandom_range(0, 3));
      v.data       = $urandom;
      v.rdata      = $urandom;
      v.rerr       = ($urandom_range(0, 7) == 0);
      v.gnt_wait   = int'($urandom_range(0, 3));
      v.rsp_wait   = int'($urandom_range(0, 3));
      if (v.addr_write) begin
        v.addr = $urandom;
        if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~((32'h1 << v.size) - 32'h1);
      end else begin
        v.addr = model_addr;
      end
      applyStimulus(modelExpect(v));
    end

    // dmactive drops while waiting for read data; response comes 3 cycles later.
    sbaccess_i = 3'd2;
    sbautoincrement_i = 1'b1;
    sbaddress_i = 32'h4000;
    sbreadonaddr_i = 1'b1;
    sbaddress_write_valid_i = 1'b1;
    @(negedge clk_i);
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i = 1'b0;
    checkOutput("abort_wr_req", 32'(master_req_o), 32'd1);
    master_gnt_i = 1'b1;
    @(negedge clk_i);
    master_gnt_i = 1'b0;
    dmactive_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checkOutput("abort_wr_busy", 32'(sbbusy_o), 32'd1);
      checkOutput("abort_wr_no_valid", 32'(sbdata_valid_o), 32'd0);
      dmactive_i = 1'b1;
    end
    master_r_valid_i = 1'b1;
    master_r_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    master_r_valid_i = 1'b0;
    checkOutput("abort_wr_idle", 32'(sbbusy_o), 32'd0);
    checkOutput("abort_wr_no_valid_end", 32'(sbdata_valid_o), 32'd0);
    checkOutput("abort_wr_no_err", 32'(sberror_valid_o), 32'd0);
    checkOutput("abort_wr_sbdata", sbdata_o, exp_sbdata);
    checkOutput("abort_wr_addr", sbaddress_o, 32'h4000);

    // dmactive drops while the request is still waiting for a grant.
    sbaddress_i = 32'h5000;
    sbreadonaddr_i = 1'b1;
    sbaddress_write_valid_i = 1'b1;
    @(negedge clk_i);
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i = 1'b0;
    checkOutput("abort_rd_req", 32'(master_req_o), 32'd1);
    dmactive_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_rd_req_drop", 32'(master_req_o), 32'd0);
    checkOutput("abort_rd_idle", 32'(sbbusy_o), 32'd0);
    dmactive_i = 1'b1;
    @(negedge clk_i);
    checkOutput("abort_rd_no_valid", 32'(sbdata_valid_o), 32'd0);
    checkOutput("abort_rd_addr", sbaddress_o, 32'h5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
